// File: rtl/aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// aes128_round_ctrl : iterative AES-128 encryptor, one round per clock,
//                     with on-the-fly key expansion and valid/ready handshakes.
// Revision 1.0
// ============================================================================
module aes128_round_ctrl #(
    parameter int N_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] c_last_round = 4'(N_ROUNDS);

    state_t         r_fsm;
    logic [127:0]   r_state;
    logic [127:0]   r_key;
    logic [127:0]   r_dout;
    logic [3:0]     r_round;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic [7:0]     w_rcon;
    logic [31:0]    w_tw;
    logic [127:0]   w_nk;
    logic [127:0]   w_sb;
    logic [127:0]   w_sr;
    logic [127:0]   w_mc;
    logic [127:0]   w_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t   = gf_mul(x, x);
        inv = t;
        for (int i = 0; i < 6; i++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // SubWord(RotWord(w3)) ^ rcon, then the chained word XORs of the schedule.
    always_comb begin
        w_tw = {sbox(r_key[23:16]) ^ w_rcon, sbox(r_key[15:8]),
                sbox(r_key[7:0]), sbox(r_key[31:24])};
        w_nk[127:96] = r_key[127:96] ^ w_tw;
        w_nk[95:64]  = r_key[95:64]  ^ w_nk[127:96];
        w_nk[63:32]  = r_key[63:32]  ^ w_nk[95:64];
        w_nk[31:0]   = r_key[31:0]   ^ w_nk[63:32];
    end

    // Byte i of the block lives at bits [127-8i -: 8]; row = i%4, column = i/4.
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[127-8*i -: 8] = sbox(r_state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
        w_next = ((r_round == c_last_round) ? w_sr : w_mc) ^ w_nk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_dout      <= '0;
            r_round     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= din ^ key_in;
                        r_key      <= key_in;
                        r_round    <= 4'd1;
                        r_fsm      <= S_ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_state <= w_next;
                    r_key   <= w_nk;
                    if (r_round == c_last_round) begin
                        r_dout      <= w_next;
                        r_fsm       <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm       <= S_IDLE;
                        r_round     <= '0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign dout      = r_dout;
    assign round     = r_round;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes128_round_ctrl : scoreboard bench for aes128_round_ctrl against a
//                        byte-array AES-128 reference model.
// Revision 1.0
// ============================================================================
module tb_aes128_round_ctrl;

    localparam logic [127:0] c_fips_pt  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_fips_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_zero_ct  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] din       = '0;
    logic [127:0] key_in    = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] dout;
    logic [3:0]   round;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   sbox_t[256];

    aes128_round_ctrl #(.N_ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy),
        .round     (round)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] q, input int n);
        logic [15:0] d;
        d = {q, q} << n;
        return d[15:8];
    endfunction

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s[16];
        logic [7:0]   k[16];
        logic [7:0]   t[16];
        logic [7:0]   tw[4];
        logic [7:0]   a[4];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tw[0] = sbox_t[k[13]] ^ rc;
            tw[1] = sbox_t[k[14]];
            tw[2] = sbox_t[k[15]];
            tw[3] = sbox_t[k[12]];
            for (int j = 0; j < 4; j++) k[j] = k[j] ^ tw[j];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[w+4*c] = t[w+4*((c+w)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
                    for (int w = 0; w < 4; w++)
                        s[4*c+w] = xt(a[w]) ^ xt(a[(w+1)%4]) ^ a[(w+1)%4]
                                 ^ a[(w+2)%4] ^ a[(w+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
            rc = xt(rc);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Monitor: inputs change just after rising edges, so a negedge sample
    // of out_valid && out_ready predicts the handshake on the next edge.
    logic [127:0] held_dout = '0;
    bit           held_v    = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else if (out_valid) begin
            if (held_v) check("dout_stable", dout, held_dout);
            held_dout = dout;
            held_v    = !out_ready;
            if (out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_output");
                else check("ciphertext", dout, exp_q.pop_front());
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] k, output int waited);
        int budget;
        budget   = 60;
        waited   = 0;
        in_valid = 1'b1;
        din      = pt;
        key_in   = k;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            waited++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(aes_ref(pt, k));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic wait_drain();
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int w;
        int n;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  128'(in_ready),  128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy",      128'(busy),      128'd0);
        check("reset_dout",      dout,            128'd0);
        check("reset_round",     128'(round),     128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 vector with intermediate state and latency checks
        out_ready = 1'b1;
        send(c_fips_pt, c_fips_key, w);
        check("edge0_state", dut.r_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("edge0_busy",  128'(busy), 128'd1);
        @(posedge clk); #1;
        check("edge1_key",   dut.r_key,   128'ha0fafe1788542cb123a339392a6c7605);
        check("edge1_state", dut.r_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        wait_out_valid(n);
        check("fips_latency", 128'(n + 1), 128'd10);
        check("fips_dout", dout, c_fips_ct);
        wait_drain();
        check("fips_in_ready_after", 128'(in_ready), 128'd1);

        // all-zero vector
        send(128'd0, 128'd0, w);
        wait_out_valid(n);
        check("zero_dout", dout, c_zero_ct);
        wait_drain();

        // input changes during rounds must not disturb the block
        send(c_fips_pt, c_fips_key, w);
        for (int i = 1; i <= 9; i++) begin
            din      = rand128();
            key_in   = rand128();
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_out_valid(n);
        check("late_change_dout", dout, c_fips_ct);
        wait_drain();

        // backpressure in DONE with a competing input
        out_ready = 1'b0;
        send(c_fips_pt, c_fips_key, w);
        wait_out_valid(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din      = rand128();
            key_in   = rand128();
            @(posedge clk); #1;
            check("bp_in_ready",  128'(in_ready),  128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_dout",      dout,            c_fips_ct);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        check("bp_release_in_ready",  128'(in_ready),  128'd1);
        check("bp_queue_empty",       128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
        check("bp_no_accept", 128'(busy), 128'd0);

        // back-to-back with in_valid held high
        send(c_fips_pt, c_fips_key, w);
        send(128'd0, 128'd0, w);
        check("b2b_second_accept_wait", 128'(w), 128'd11);
        wait_drain();

        // reset while round 5 is in flight
        send(c_fips_pt, c_fips_key, w);
        n = 0;
        while (round != 4'd5 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (round != 4'd5) fail_now("round5_timeout");
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_in_ready",  128'(in_ready),  128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_busy",      128'(busy),      128'd0);
        check("midrst_dout",      dout,            128'd0);
        check("midrst_round",     128'(round),     128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", 128'(in_ready), 128'd1);
        send(c_fips_pt, c_fips_key, w);
        wait_out_valid(n);
        check("postrst_dout", dout, c_fips_ct);
        wait_drain();

        // randomized blocks with random sink stalls
        for (int b = 0; b < 8; b++) begin
            out_ready = 1'b0;
            send(rand128(), rand128(), w);
            wait_out_valid(n);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            wait_drain();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Iterative AES-128 encryption engine controller: one 128-bit block per transaction, one round per clock.
- Holds the state register, round counter and on-the-fly key-expansion register.
- Sequences the team's combinational SubBytes, ShiftRows, MixColumns and addRoundKey blocks over 10 rounds.
- Sits between a block source and a ciphertext sink, with valid/ready handshakes on both sides.

Parameters:
- N_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext and key present.
- in_ready  output  1  engine can accept a block.
- din  input  128  plaintext, byte 0 in bits [127:120].
- key_in  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  sink accepts ciphertext.
- dout  output  128  ciphertext.
- busy  output  1  high while in ROUND.
- round  output  4  current round index (debug).

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; state_reg, key_reg, dout = 0; round = 0.
  - in_ready = 1, out_valid = 0, busy = 0.
  - Applies at any time, including mid-block. The in-flight block is discarded with no partial output.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: state_reg <= din ^ key_in (round-0 AddRoundKey), key_reg <= key_in, round <= 1, go to ROUND.
  - din and key_in are sampled only at the accept edge.
- ROUND (in_ready = 0, busy = 1), each cycle:
  - nk = expand(key_reg, rcon[round]).
  - expand: w3' = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0' = w0 ^ w3'; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3'' = w3 ^ w2'.
  - rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - round < 10: state_reg <= addRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), nk).
  - round == 10: MixColumns is omitted.
  - key_reg <= nk.
  - round < 10: round <= round + 1.
  - round == 10: go to DONE.
- DONE:
  - out_valid = 1; dout = state_reg, stable until handshake.
  - in_ready = 0.
  - On out_ready: go to IDLE, round <= 0, out_valid deasserts next cycle.
- Latency:
  - Accept edge = edge 0; round r completes at edge r.
  - out_valid is high from edge 10.
  - With out_ready held high, the handshake occurs at edge 11 and in_ready is high again after edge 11.
  - Minimum spacing between accepts is 12 cycles.
- in_valid while not in IDLE is ignored; no buffering.
- out_ready while not in DONE is ignored.
- Backpressure is unbounded: DONE holds indefinitely with dout and out_valid stable.
- round never exceeds 10; the counter does not wrap.
- All XORs and byte operations are GF(2^8), width-exact 128-bit; no carries.

Test Plan:
- FIPS-197 vector: din 3243f6a8885a308d313198a2e0370734, key_in 2b7e151628aed2a6abf7158809cf4f3c, out_ready = 1. Required:
  - After edge 0: state_reg = 193de3bea0f4e22b9ac68d2ae9f84808.
  - After edge 1: key_reg = a0fafe1788542cb123a339392a6c7605, state_reg = a49c7ff2689f352b6b5bea43026a5049.
  - out_valid from edge 10 with dout = 3925841d02dc09fbdc118597196a0b32.
- All-zero din and key -> dout = 66e94bd4ef8a2c3b884cfa59ca342b2e after 10 cycles.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE, with din/key_in changed and in_valid = 1 -> dout, out_valid stable, in_ready = 0, no accept. Raise out_ready -> single handshake, then IDLE.
- Back-to-back: present the FIPS vector then the zero vector with in_valid held high -> second accept in the first IDLE cycle after the first handshake; both ciphertexts correct, in order.
- Reset mid-operation: pull rst_n low while round = 5 -> outputs zero immediately, no out_valid pulse. After release, in_ready = 1 and a new FIPS block encrypts correctly.
- Late input changes: alter din/key_in on cycles 1-9 of a block -> ciphertext unaffected (FIPS result unchanged).
